core_exec_div: RTL and testbench

- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage beside the ALU and multiplier.
- Its registered result drives the div_result input of the execute-result selector when the decoder picks the DIV engine.
- Multi-cycle: the core issues a request, stalls on busy, and captures the result on the done pulse.

---
 rtl/core_exec_div.sv | 184 ++++++++++++++++++
 tb/tb_core_exec_div.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/core_exec_div.sv
// core_exec_div
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// A request is accepted in IDLE. Divide-by-zero and signed overflow are
// resolved at accept and go straight to DONE. Every other request runs
// 32 CALC cycles, one quotient bit per cycle, and then one DONE cycle.
//
// Ports:
//   clk         core clock
//   rst         synchronous active-high reset
//   flush       kill any in-flight operation; returns to IDLE with no done pulse
//   req_valid   start request
//   req_ready   high when a request can be accepted (state == IDLE)
//   req_op      00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   req_a       dividend (rs1)
//   req_b       divisor (rs2)
//   busy        operation in flight (state == CALC)
//   done        one-cycle pulse, div_result valid (state == DONE)
//   div_result  registered quotient or remainder

module core_exec_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] div_result
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic            isRem_q,   isRem_d;
    logic            quoNeg_q,  quoNeg_d;
    logic            remNeg_q,  remNeg_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] quo_q,     quo_d;
    logic [XLEN-1:0] rem_q,     rem_d;
    logic [XLEN-1:0] result_q,  result_d;

    // Request decode: op bit 0 clear means signed, op bit 1 set means remainder.
    logic            opSigned;
    logic            opRem;
    logic            aNeg;
    logic            bNeg;
    logic [XLEN-1:0] absA;
    logic [XLEN-1:0] absB;
    logic            bZero;
    logic            sOverflow;
    logic [XLEN-1:0] specialVal;

    assign opSigned  = ~req_op[0];
    assign opRem     = req_op[1];
    assign aNeg      = opSigned & req_a[XLEN-1];
    assign bNeg      = opSigned & req_b[XLEN-1];
    assign absA      = aNeg ? -req_a : req_a;
    assign absB      = bNeg ? -req_b : req_b;
    assign bZero     = (req_b == '0);
    assign sOverflow = opSigned && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);

    always_comb begin
        specialVal = '0;
        if (bZero) begin
            specialVal = opRem ? req_a : '1;
        end else if (sOverflow) begin
            specialVal = opRem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One restoring step. The dividend sits in quo_q and shifts out of its MSB
    // while quotient bits shift in at the LSB. The remainder always stays below
    // the divisor, so XLEN bits hold it; only the trial difference needs XLEN+1.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            bitSet;
    logic [XLEN-1:0] remNext;
    logic [XLEN-1:0] quoNext;
    logic [XLEN-1:0] finalQuo;
    logic [XLEN-1:0] finalRem;

    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {1'b0, divisor_q};
    assign bitSet   = ~diff[XLEN];
    assign remNext  = bitSet ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quoNext  = {quo_q[XLEN-2:0], bitSet};
    assign finalQuo = quoNeg_q ? -quoNext : quoNext;
    assign finalRem = remNeg_q ? -remNext : remNext;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        isRem_d   = isRem_q;
        quoNeg_d  = quoNeg_q;
        remNeg_d  = remNeg_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    isRem_d  = opRem;
                    quoNeg_d = aNeg ^ bNeg;
                    remNeg_d = aNeg;
                    if (bZero || sOverflow) begin
                        result_d = specialVal;
                        state_d  = ST_DONE;
                    end else begin
                        divisor_d = absB;
                        quo_d     = absA;
                        rem_d     = '0;
                        cnt_d     = CNT_W'(XLEN - 1);
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = remNext;
                quo_d = quoNext;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d    = '0;
                    result_d = isRem_q ? finalRem : finalQuo;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush abandons whatever is in flight; the last delivered result stays visible.
        if (flush) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            isRem_q   <= 1'b0;
            quoNeg_q  <= 1'b0;
            remNeg_q  <= 1'b0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isRem_q   <= isRem_d;
            quoNeg_q  <= quoNeg_d;
            remNeg_q  <= remNeg_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_CALC);
    assign done       = (state_q == ST_DONE);
    assign div_result = result_q;

endmodule

// File: tb/tb_core_exec_div.sv
// tb_core_exec_div
// Directed-vector bench for core_exec_div. Stimulus pushes the hand-computed
// result and the cycle in which done must appear into a queue; an independent
// monitor pops and compares whenever done is seen.

module tb_core_exec_div;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        busy;
    logic        done;
    logic [31:0] div_result;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] lastResult = 32'h0;

    core_exec_div #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .busy       (busy),
        .done       (done),
        .div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedDone: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_result"}, div_result, e.val);
                checkOutput({e.name, "_doneCycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge. Holds req_valid until the DUT is ready; the request
    // is then taken at the coming posedge (cycle cyc). Returns at the next negedge.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit push, input logic [31:0] expv, input int lat,
                                 input string name, input bit hold, output int accCyc);
        int budget;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        budget    = 0;
        while (!req_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        accCyc = cyc;
        if (!req_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_acceptTimeout: got req_ready=0 expected req_ready=1", name);
            req_valid = 1'b0;
        end else begin
            if (push) begin
                exp_t e;
                e.val  = expv;
                e.cyc  = cyc + lat;
                e.name = name;
                sb.push_back(e);
                lastResult = expv;
            end
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
        end
    endtask

    task automatic waitDrain(input string name);
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        checkOutput({name, "_drained"}, 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int lat, input string name);
        int acc;
        applyStimulus(op, a, b, 1'b1, expv, lat, name, 1'b0, acc);
        waitDrain(name);
    endtask

    initial begin
        int acc;
        int acc1;
        int acc2;

        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = 32'h0;
        req_b     = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset_req_ready",  {31'b0, req_ready}, 32'd1);
        checkOutput("reset_busy",       {31'b0, busy},      32'd0);
        checkOutput("reset_done",       {31'b0, done},      32'd0);
        checkOutput("reset_div_result", div_result,         32'h0);

        // Special cases: done one cycle after accept.
        runOp(OP_DIVU, 32'd5,        32'd0,        32'hFFFF_FFFF, 1, "divuByZero");
        runOp(OP_REM,  32'h8000_0000, 32'd0,       32'h8000_0000, 1, "remByZero");
        runOp(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "divOverflow");
        runOp(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "remOverflow");

        // Normal path: 33 cycles from accept to done.
        runOp(OP_DIVU, 32'd100,       32'd7,         32'd14,        33, "divu100by7");
        runOp(OP_REMU, 32'd100,       32'd7,         32'd2,         33, "remu100by7");
        runOp(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "divNeg7by2");
        runOp(OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "remNeg7by2");
        runOp(OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33, "rem7byNeg2");
        runOp(OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, "divuMaxBy1");
        runOp(OP_DIV,  32'h8000_0000, 32'd2,         32'hC000_0000, 33, "divMinBy2");

        // Flush during CALC at cycle 10 after accept.
        applyStimulus(OP_DIVU, 32'd1000, 32'd3, 1'b0, 32'h0, 0, "flushVictim", 1'b0, acc);
        while (cyc != acc + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_req_ready",  {31'b0, req_ready}, 32'd1);
        checkOutput("flush_busy",       {31'b0, busy},      32'd0);
        checkOutput("flush_div_result", div_result,         lastResult);
        applyStimulus(OP_DIVU, 32'd1000, 32'd3, 1'b1, 32'd333, 33, "afterFlush", 1'b0, acc2);
        checkOutput("afterFlush_acceptCycle", 32'(acc2), 32'(acc + 11));
        waitDrain("afterFlush");

        // Flush together with req_valid in IDLE: request must be dropped.
        req_op    = OP_DIVU;
        req_a     = 32'd9;
        req_b     = 32'd3;
        req_valid = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        checkOutput("flushReq_busy",      {31'b0, busy},      32'd0);
        checkOutput("flushReq_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);

        // Back-to-back: req_valid held high; second accept one cycle after first done.
        applyStimulus(OP_DIVU, 32'd50, 32'd5, 1'b1, 32'd10, 33, "b2bFirst",  1'b1, acc1);
        applyStimulus(OP_REMU, 32'd50, 32'd7, 1'b1, 32'd1,  33, "b2bSecond", 1'b0, acc2);
        checkOutput("b2b_acceptCycle", 32'(acc2), 32'(acc1 + 34));
        waitDrain("b2b");

        // Reset during CALC.
        applyStimulus(OP_DIVU, 32'd77, 32'd5, 1'b0, 32'h0, 0, "rstVictim", 1'b0, acc);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRst_req_ready",  {31'b0, req_ready}, 32'd1);
        checkOutput("midRst_busy",       {31'b0, busy},      32'd0);
        checkOutput("midRst_done",       {31'b0, done},      32'd0);
        checkOutput("midRst_div_result", div_result,         32'h0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        checkOutput("final_queueEmpty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
